conv2_requant_relu: RTL and testbench
=====================================

CONV2_REQUANT_RELU -- requirements
Module: conv2_requant_relu

Interface
REQ-001 Parameter PSUM_WIDTH, default 20, signed width of one per-channel partial sum.
REQ-002 Parameter ACC_WIDTH, default 26, signed accumulator and bias width.
REQ-003 Parameter DATA_WIDTH, default 8, output pixel width.
REQ-004 Parameter NUM_CH, default 6, partial sums per output pixel (input channels).
REQ-005 Parameter FMAP_W / FMAP_H, default 24 / 24, conv2 output map size; FMAP_W SHALL be even.
REQ-006 clk  in  1  single clock, rising edge.
REQ-007 resetn  in  1  asynchronous, active-low reset.
REQ-008 start  in  1  one-cycle pulse that begins a filter; samples bias_in and shift_in.
REQ-009 bias_in  in  ACC_WIDTH  signed filter bias.
REQ-010 shift_in  in  5  requantization right-shift amount, 0..24.
REQ-011 psum_valid  in  1  psum_in qualifier.
REQ-012 psum_in  in  PSUM_WIDTH  signed partial sum; channel-serial, NUM_CH per pixel, raster order.
REQ-013 new_filter  out  1  one-cycle pulse to the downstream pool stage at filter start.
REQ-014 data_valid  out  1  pixel qualifier.
REQ-015 data_out  out  DATA_WIDTH  requantized pixel.
REQ-016 busy  out  1  high while a filter is in progress.
REQ-017 filter_done  out  1  one-cycle pulse coincident with the last pixel of a filter.

Function
REQ-018 FSM SHALL have states IDLE, ACCUM, FLUSH; reset state IDLE.
REQ-019 IDLE: start SHALL latch bias/shift, clear the counters and accumulator, assert new_filter the next cycle, and move to ACCUM; psum_valid in IDLE SHALL be ignored.
REQ-020 ACCUM: each psum_valid SHALL add sign-extended psum_in to acc and increment ch_cnt, which wraps at NUM_CH-1.
REQ-021 On the NUM_CH-th psum of a pixel, the pixel value SHALL be acc+psum_in+bias, and acc SHALL restart from 0 the same cycle, so back-to-back pixels lose no data.
REQ-022 Requant: v = (sum + (shift>0 ? 1<<(shift-1) : 0)) >>> shift, arithmetic shift, round half-up.
REQ-023 Saturation: clamp v to [0, 2^DATA_WIDTH-1] (see REQ-034).
REQ-024 Pairing: an even-column pixel SHALL be held in a pair register and not output.
REQ-025 When the odd-column pixel of the pair completes, data_valid SHALL be high for two consecutive cycles: first the held pixel, then the odd pixel. Output latency is 1 cycle after the odd pixel's last psum.
REQ-026 psum_valid arriving during the second output cycle SHALL be accepted without loss.
REQ-027 pix_cnt SHALL count 0..FMAP_W*FMAP_H-1; the last pixel's pair SHALL move the FSM to FLUSH.
REQ-028 FLUSH: emit the final pair, pulse filter_done with the final data_valid, then return to IDLE.
REQ-029 start while busy SHALL be ignored; busy = (state != IDLE).
REQ-030 Gaps in psum_valid SHALL stall accumulation only; there is no timeout.

Reset
REQ-031 On resetn low: state IDLE, acc/counters/pair register 0, and all outputs 0, including new_filter, data_valid, data_out, busy and filter_done.
REQ-032 Reset mid-filter SHALL abandon the filter; no partial output afterwards.

Configuration
REQ-033 Macro CONV2_RELU_EN defined: negative v clamps to 0 (ReLU), and data_out is unsigned 0..255.
REQ-034 CONV2_RELU_EN undefined: v saturates to signed [-128,127], and data_out is two's complement.

Structure
REQ-035 Shared package conv2_pkg SHALL hold PSUM_WIDTH, ACC_WIDTH, DATA_WIDTH, NUM_CH, FMAP_W, FMAP_H defaults and the FSM state encoding.
REQ-036 Rounding/shift/saturation SHALL live in combinational sub-module conv2_requant_unit, instanced once.

Verification
REQ-037 Rounding: start bias=4 shift=2, six psums of 10 (sum 64) -> data_out 16; psums summing 6, bias 0, shift 2 -> data_out 2.
REQ-038 ReLU/saturation: psums of -100 -> 0 (with macro) or -128 saturated/-150>>>0 checked (without); psums of 100000, shift 0 -> 255 (with macro) or 127 (without).
REQ-039 Pairing: continuous psum stream for one 24x24 filter -> 576 data_valid cycles, all in back-to-back pairs, new_filter once 1 cycle after start, filter_done on the 576th valid, busy low afterwards.
REQ-040 Protocol: start pulsed mid-filter -> ignored and the count is unchanged; random psum_valid gaps -> identical output values and order as the gap-free run.
REQ-041 Reset: resetn low after pixel 100 -> all outputs 0 immediately; a new start then yields a full correct 576-pixel filter.

Source files
------------

// File: rtl/conv2_pkg.sv
// -----------------------------------------------------------------------------
// conv2_pkg
// Shared definitions for the conv2 requantization / ReLU output stage.
//   - Default widths and feature-map geometry used as parameter defaults by
//     conv2_requant_relu and conv2_requant_unit.
//   - FSM state encoding for the filter sequencer.
// No ports (package).
// -----------------------------------------------------------------------------
package conv2_pkg;

  localparam int DEF_PSUM_WIDTH = 20;  // signed per-channel partial sum
  localparam int DEF_ACC_WIDTH  = 26;  // signed accumulator / bias
  localparam int DEF_DATA_WIDTH = 8;   // output pixel
  localparam int DEF_NUM_CH     = 6;   // partial sums per output pixel
  localparam int DEF_FMAP_W     = 24;  // output map width (must be even)
  localparam int DEF_FMAP_H     = 24;  // output map height

  // Filter sequencer states. Encoding is visible on the debug port.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

endpackage

// File: rtl/conv2_requant_unit.sv
// -----------------------------------------------------------------------------
// conv2_requant_unit
// Purely combinational requantizer: round-half-up arithmetic right shift of a
// signed accumulated sum, followed by saturation to the output pixel range.
//
// Configuration macro: CONV2_RELU_EN
//   defined   : negative results clamp to 0 (ReLU), output unsigned
//               0 .. 2^DATA_WIDTH-1.
//   undefined : output saturates to the signed range
//               -2^(DATA_WIDTH-1) .. 2^(DATA_WIDTH-1)-1 (two's complement).
//
// Ports
//   i_sum   in  ACC_WIDTH   signed sum (acc + last psum + bias)
//   i_shift in  5           right-shift amount 0..24
//   o_pix   out DATA_WIDTH  requantized, saturated pixel
// -----------------------------------------------------------------------------
module conv2_requant_unit
  import conv2_pkg::*;
#(
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic signed [ACC_WIDTH-1:0]  i_sum,
  input  logic        [4:0]            i_shift,
  output logic        [DATA_WIDTH-1:0] o_pix
);

  // One guard bit so adding the rounding constant can never wrap.
  localparam int EW = ACC_WIDTH + 1;

`ifdef CONV2_RELU_EN
  localparam logic signed [EW-1:0] MAX_V = EW'((1 << DATA_WIDTH) - 1);
  localparam logic signed [EW-1:0] MIN_V = '0;
`else
  localparam logic signed [EW-1:0] MAX_V = EW'((1 << (DATA_WIDTH - 1)) - 1);
  localparam logic signed [EW-1:0] MIN_V = -(EW'(1 << (DATA_WIDTH - 1)));
`endif

  logic signed [EW-1:0] w_ext;
  logic signed [EW-1:0] w_rnd;
  logic signed [EW-1:0] w_v;

  always_comb begin
    w_ext = EW'(i_sum);
    // Half of one output LSB; zero when there is no shift.
    w_rnd = '0;
    if (i_shift != 5'd0) begin
      w_rnd = EW'(1) << (i_shift - 5'd1);
    end
    // Arithmetic shift floors toward -inf, so +half gives round-half-up.
    w_v = (w_ext + w_rnd) >>> i_shift;

    if (w_v > MAX_V) begin
      o_pix = MAX_V[DATA_WIDTH-1:0];
    end else if (w_v < MIN_V) begin
      o_pix = MIN_V[DATA_WIDTH-1:0];
    end else begin
      o_pix = w_v[DATA_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/conv2_requant_relu.sv
// -----------------------------------------------------------------------------
// conv2_requant_relu
// Accumulates channel-serial partial sums into output pixels, adds the filter
// bias, requantizes (round, shift, saturate / ReLU) and emits pixels in
// horizontally adjacent pairs to the downstream pooling stage.
//
// Configuration macro: CONV2_RELU_EN (see conv2_requant_unit). Default build
// (macro undefined) outputs signed saturated pixels.
//
// Handshake: psum_in is consumed on every rising edge where psum_valid is high
// and the block is accumulating; there is no back-pressure. data_out is
// meaningful only while data_valid is high. Each pair is two consecutive
// data_valid cycles, even column first.
//
// Ports
//   clk          in   1            clock, rising edge
//   resetn       in   1            asynchronous active-low reset
//   start        in   1            begin a filter (ignored while busy)
//   bias_in      in   ACC_WIDTH    signed filter bias, sampled with start
//   shift_in     in   5            requant shift 0..24, sampled with start
//   psum_valid   in   1            psum_in qualifier
//   psum_in      in   PSUM_WIDTH   signed partial sum, channel-serial
//   new_filter   out  1            pulse one cycle after an accepted start
//   data_valid   out  1            pixel qualifier
//   data_out     out  DATA_WIDTH   requantized pixel
//   busy         out  1            filter in progress (state != IDLE)
//   filter_done  out  1            pulse with the last pixel of a filter
//   o_dbg_state  out  2            FSM state (conv2_pkg::state_t encoding)
// -----------------------------------------------------------------------------
module conv2_requant_relu
  import conv2_pkg::*;
#(
  parameter int PSUM_WIDTH = DEF_PSUM_WIDTH,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_CH     = DEF_NUM_CH,
  parameter int FMAP_W     = DEF_FMAP_W,
  parameter int FMAP_H     = DEF_FMAP_H
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         start,
  input  logic signed [ACC_WIDTH-1:0]  bias_in,
  input  logic        [4:0]            shift_in,
  input  logic                         psum_valid,
  input  logic signed [PSUM_WIDTH-1:0] psum_in,
  output logic                         new_filter,
  output logic                         data_valid,
  output logic        [DATA_WIDTH-1:0] data_out,
  output logic                         busy,
  output logic                         filter_done,
  output logic        [1:0]            o_dbg_state
);

  localparam int NPIX  = FMAP_W * FMAP_H;
  localparam int PIX_W = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CH - 1);
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(NPIX - 1);

  // Sequencer
  state_t r_state;
  state_t w_next;

  // Filter configuration
  logic signed [ACC_WIDTH-1:0] r_bias;
  logic        [4:0]           r_shift;

  // Accumulation
  logic signed [ACC_WIDTH-1:0] r_acc;
  logic        [CH_W-1:0]      r_ch_cnt;
  logic        [PIX_W-1:0]     r_pix_cnt;

  // Pairing: even-column pixel waits in r_pair; the odd pixel of a completed
  // pair waits one cycle in r_pend behind the even one.
  logic [DATA_WIDTH-1:0] r_pair;
  logic [DATA_WIDTH-1:0] r_pend;
  logic                  r_pend_valid;

  // Registered outputs
  logic                  r_new_filter;
  logic                  r_data_valid;
  logic [DATA_WIDTH-1:0] r_data_out;
  logic                  r_filter_done;

  // Control strobes
  logic w_start_ok;
  logic w_accept;
  logic w_pix_done;
  logic w_last_pix;

  // Datapath
  logic signed [ACC_WIDTH-1:0] w_psum_ext;
  logic signed [ACC_WIDTH-1:0] w_sum;
  logic        [DATA_WIDTH-1:0] w_pix;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and control strobes
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next     = r_state;
    w_start_ok = 1'b0;
    w_accept   = 1'b0;
    w_pix_done = 1'b0;
    w_last_pix = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // psum_valid is deliberately not looked at here.
        w_start_ok = start;
        if (start) begin
          w_next = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        w_accept   = psum_valid;
        w_pix_done = psum_valid && (r_ch_cnt == CH_LAST);
        w_last_pix = w_pix_done && (r_pix_cnt == PIX_LAST);
        if (w_last_pix) begin
          w_next = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        // Only the odd pixel of the final pair is still owed.
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Pixel sum and requantization. The finishing psum and the bias are added
  // combinationally so acc can restart at zero on the same edge.
  // ---------------------------------------------------------------------------
  assign w_psum_ext = ACC_WIDTH'(psum_in);
  assign w_sum      = r_acc + w_psum_ext + r_bias;

  conv2_requant_unit #(
    .ACC_WIDTH  (ACC_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_requant (
    .i_sum   (w_sum),
    .i_shift (r_shift),
    .o_pix   (w_pix)
  );

  // ---------------------------------------------------------------------------
  // Datapath, counters and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_bias        <= '0;
      r_shift       <= '0;
      r_acc         <= '0;
      r_ch_cnt      <= '0;
      r_pix_cnt     <= '0;
      r_pair        <= '0;
      r_pend        <= '0;
      r_pend_valid  <= 1'b0;
      r_new_filter  <= 1'b0;
      r_data_valid  <= 1'b0;
      r_data_out    <= '0;
      r_filter_done <= 1'b0;
    end else begin
      r_new_filter  <= 1'b0;
      r_data_valid  <= 1'b0;
      r_filter_done <= 1'b0;

      if (w_start_ok) begin
        r_bias       <= bias_in;
        r_shift      <= shift_in;
        r_acc        <= '0;
        r_ch_cnt     <= '0;
        r_pix_cnt    <= '0;
        r_pair       <= '0;
        r_pend_valid <= 1'b0;
        r_new_filter <= 1'b1;
      end

      if (w_accept) begin
        if (w_pix_done) begin
          r_acc    <= '0;
          r_ch_cnt <= '0;
          r_pix_cnt <= w_last_pix ? '0 : r_pix_cnt + PIX_W'(1);
          // FMAP_W is even, so the raster index parity is the column parity.
          if (!r_pix_cnt[0]) begin
            r_pair <= w_pix;
          end else begin
            r_data_valid <= 1'b1;
            r_data_out   <= r_pair;
            r_pend       <= w_pix;
            r_pend_valid <= 1'b1;
          end
        end else begin
          r_acc    <= r_acc + w_psum_ext;
          r_ch_cnt <= r_ch_cnt + CH_W'(1);
        end
      end

      // Second half of a pair. A new pair needs at least two more completed
      // pixels, so this never collides with the branch above.
      if (r_pend_valid) begin
        r_data_valid <= 1'b1;
        r_data_out   <= r_pend;
        r_pend_valid <= 1'b0;
        if (r_state == ST_FLUSH) begin
          r_filter_done <= 1'b1;
        end
      end
    end
  end

  assign new_filter  = r_new_filter;
  assign data_valid  = r_data_valid;
  assign data_out    = r_data_out;
  assign filter_done = r_filter_done;
  assign busy        = (r_state != ST_IDLE);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_conv2_requant_relu.sv
// -----------------------------------------------------------------------------
// tb_conv2_requant_relu
// Self-checking bench for conv2_requant_relu (default geometry 24x24, 6 ch).
// Honors CONV2_RELU_EN for expected values.
// -----------------------------------------------------------------------------
module tb_conv2_requant_relu;

  localparam int PW   = 20;
  localparam int AW   = 26;
  localparam int DW   = 8;
  localparam int NCH  = 6;
  localparam int FW   = 24;
  localparam int FH   = 24;
  localparam int NPIX = FW * FH;
  localparam int NV   = 11;

`ifdef CONV2_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic start = 1'b0;
  logic signed [AW-1:0] bias_in = '0;
  logic [4:0] shift_in = '0;
  logic psum_valid = 1'b0;
  logic signed [PW-1:0] psum_in = '0;
  logic new_filter, data_valid, busy, filter_done;
  logic [DW-1:0] data_out;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  conv2_requant_relu #(
    .PSUM_WIDTH (PW), .ACC_WIDTH (AW), .DATA_WIDTH (DW),
    .NUM_CH (NCH), .FMAP_W (FW), .FMAP_H (FH)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .start       (start),
    .bias_in     (bias_in),
    .shift_in    (shift_in),
    .psum_valid  (psum_valid),
    .psum_in     (psum_in),
    .new_filter  (new_filter),
    .data_valid  (data_valid),
    .data_out    (data_out),
    .busy        (busy),
    .filter_done (filter_done),
    .o_dbg_state (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------------
  int n_tests = 0;
  int n_fail  = 0;
  int n_valid = 0;
  int nf_cnt  = 0;
  int done_cnt = 0;
  int run_len = 0;
  int v_base = 0;
  int exp_total = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] mon_e;
  int got[4096];
  int psum_mem[NPIX*NCH];

  typedef struct {
    int bias;
    int shift;
    int ps[NCH];
    int exp_signed;
    int exp_relu;
  } vec_t;
  vec_t tv[NV];

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: pixel = clamp(floor((sum + half) / 2^shift))
  // ---------------------------------------------------------------------------
  function automatic logic [DW-1:0] model_pix(input longint sum, input int shift);
    longint half;
    longint v;
    half = (shift > 0) ? (longint'(1) << (shift - 1)) : 64'sd0;
    v = (sum + half) >>> shift;
    if (RELU) begin
      if (v < 0) v = 0;
      if (v > 255) v = 255;
    end else begin
      if (v < -128) v = -128;
      if (v > 127) v = 127;
    end
    return v[DW-1:0];
  endfunction

  task automatic push_expected(input int b, input int s, input int first, input int count);
    longint sum;
    for (int p = first; p < first + count; p++) begin
      sum = b;
      for (int c = 0; c < NCH; c++) sum += psum_mem[p*NCH + c];
      exp_q.push_back(model_pix(sum, s));
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scoreboard / monitor (samples on the falling edge)
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (resetn) begin
      if (new_filter) nf_cnt++;
      if (data_valid) begin
        if (n_valid < 4096) got[n_valid] = int'(data_out);
        n_valid++;
        run_len++;
        if (exp_q.size() == 0) begin
          check("unexpected_valid_qsize", exp_q.size(), 1);
        end else begin
          mon_e = exp_q.pop_front();
          check("data_out", data_out, mon_e);
        end
      end else if (run_len != 0) begin
        check("pair_len", run_len, 2);
        run_len = 0;
      end
      if (filter_done) begin
        check("done_with_valid", data_valid, 1);
        check("done_on_last_valid", n_valid - v_base, exp_total);
        done_cnt++;
      end
    end else begin
      run_len = 0;
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    resetn = 1'b0;
    start = 1'b0;
    psum_valid = 1'b0;
    repeat (3) tick();
    resetn = 1'b1;
    tick();
  endtask

  task automatic do_start(input int b, input int s);
    bias_in = AW'(b);
    shift_in = 5'(s);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("new_filter_after_start", new_filter, 1);
    check("busy_after_start", busy, 1);
  endtask

  // Feeds pixels [first, first+count). gap_pct: chance of an idle cycle before
  // each psum. mid_start_pix: pixel at which a stray start pulse is injected.
  task automatic feed(input int first, input int count, input int gap_pct, input int mid_start_pix);
    for (int p = first; p < first + count; p++) begin
      for (int c = 0; c < NCH; c++) begin
        if (gap_pct > 0) begin
          while ($urandom_range(99, 0) < gap_pct) begin
            psum_valid = 1'b0;
            tick();
          end
        end
        psum_valid = 1'b1;
        psum_in = PW'(psum_mem[p*NCH + c]);
        start = (p == mid_start_pix) && (c == 0);
        if (start) bias_in = AW'(12345);
        tick();
        start = 1'b0;
      end
    end
    psum_valid = 1'b0;
  endtask

  task automatic fill_random();
    for (int i = 0; i < NPIX*NCH; i++) psum_mem[i] = int'($urandom_range(4000, 0)) - 2000;
  endtask

  task automatic run_full(input int b, input int s, input int gap_pct, input int mid_start_pix);
    int v0, d0, n0;
    v0 = n_valid;
    d0 = done_cnt;
    n0 = nf_cnt;
    v_base = n_valid;
    exp_total = NPIX;
    push_expected(b, s, 0, NPIX);
    do_start(b, s);
    feed(0, NPIX, gap_pct, mid_start_pix);
    for (int k = 0; k < 20 && done_cnt == d0; k++) tick();
    check("filter_done_count", done_cnt - d0, 1);
    check("valid_count", n_valid - v0, NPIX);
    check("new_filter_count", nf_cnt - n0, 1);
    check("busy_after_done", busy, 0);
    check("exp_q_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  // ---------------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------------
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    int b, s, base_a, base_b, mism, v0;

    //            bias      sh  psums                                 signed relu
    tv[0]  = '{4,        2,  '{10, 10, 10, 10, 10, 10},               16,   16};
    tv[1]  = '{0,        2,  '{1, 1, 1, 1, 1, 1},                     2,    2};
    tv[2]  = '{0,        0,  '{-100, -100, -100, -100, -100, -100},   -128, 0};
    tv[3]  = '{0,        2,  '{-25, -25, -25, -25, -25, -25},         -37,  0};
    tv[4]  = '{0,        0,  '{-25, -25, -25, -25, -25, -25},         -128, 0};
    tv[5]  = '{0,        0,  '{100000, 100000, 100000, 100000, 100000, 100000}, 127, 255};
    tv[6]  = '{0,        1,  '{5, 0, 0, 0, 0, 0},                     3,    3};
    tv[7]  = '{-3,       1,  '{0, 0, 0, 0, 0, 0},                     -1,   0};
    tv[8]  = '{16777216, 24, '{0, 0, 0, 0, 0, 0},                     1,    1};
    tv[9]  = '{0,        0,  '{200, 0, 0, 0, 0, 0},                   127,  200};
    tv[10] = '{0,        3,  '{-4, 0, 0, 0, 0, 0},                    0,    0};

    // Reset state
    tick();
    tick();
    check("rst_new_filter", new_filter, 0);
    check("rst_data_valid", data_valid, 0);
    check("rst_data_out", data_out, 0);
    check("rst_busy", busy, 0);
    check("rst_filter_done", filter_done, 0);
    check("rst_state", dbg_state, 0);
    resetn = 1'b1;
    tick();

    // Table vectors: one even/odd pair each, checking latency and pair shape.
    for (int i = 0; i < NV; i++) begin
      apply_reset();
      for (int c = 0; c < NCH; c++) begin
        psum_mem[c] = tv[i].ps[c];
        psum_mem[NCH + c] = tv[i].ps[c];
      end
      exp_q.push_back(DW'(RELU ? tv[i].exp_relu : tv[i].exp_signed));
      exp_q.push_back(DW'(RELU ? tv[i].exp_relu : tv[i].exp_signed));
      v_base = n_valid;
      exp_total = 0;
      do_start(tv[i].bias, tv[i].shift);
      feed(0, 2, 0, -1);
      check("vec_latency_first", data_valid, 1);
      tick();
      check("vec_latency_second", data_valid, 1);
      tick();
      check("vec_pair_end", data_valid, 0);
      check("vec_drained", exp_q.size(), 0);
      exp_q.delete();
    end
    apply_reset();

    // Full filter, continuous stream
    fill_random();
    b = int'($urandom_range(40000, 0)) - 20000;
    s = int'($urandom_range(8, 0));
    base_a = n_valid;
    run_full(b, s, 0, -1);

    // Same data with random gaps: same values, same order
    base_b = n_valid;
    run_full(b, s, 30, -1);
    mism = 0;
    for (int k = 0; k < NPIX; k++) begin
      if (base_b + k < 4096 && got[base_a + k] != got[base_b + k]) mism++;
    end
    check("gap_vs_nogap_mismatches", mism, 0);

    // Start pulsed mid-filter is ignored
    fill_random();
    b = int'($urandom_range(2000, 0)) - 1000;
    run_full(b, 4, 0, 200);

    // Reset after pixel 100 abandons the filter
    fill_random();
    b = int'($urandom_range(2000, 0)) - 1000;
    s = int'($urandom_range(6, 2));
    push_expected(b, s, 0, NPIX);
    v0 = n_valid;
    do_start(b, s);
    feed(0, 101, 0, -1);
    repeat (3) tick();
    resetn = 1'b0;
    #1;
    check("midrst_new_filter", new_filter, 0);
    check("midrst_data_valid", data_valid, 0);
    check("midrst_data_out", data_out, 0);
    check("midrst_busy", busy, 0);
    check("midrst_filter_done", filter_done, 0);
    check("midrst_state", dbg_state, 0);
    check("midrst_valids_before", n_valid - v0, 100);
    exp_q.delete();
    tick();
    tick();
    resetn = 1'b1;
    repeat (5) tick();
    check("midrst_no_output_after", n_valid - v0, 100);

    // Fresh full filter after the abandoned one
    fill_random();
    b = int'($urandom_range(40000, 0)) - 20000;
    s = int'($urandom_range(10, 0));
    run_full(b, s, 0, -1);

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
